term_sequencer: RTL

Parametrised term-index sequencer for the series-evaluation datapath. It issues an index stream (term, channel) to the multiply-accumulate pipeline under a valid/ready handshake. The stream has a programmable term count, up or down direction, and NUM_CH interleaved channels per term. It drives the coefficient ROM read enable once per term and reports completion with a one-cycle done pulse. It replaces the fixed free-running term counter between the control FSM and the coefficient ROM / MAC array.

---
 rtl/term_seq_pkg.sv | 18 +
 rtl/term_idx_ctr.sv | 54 +++++
 rtl/term_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/term_seq_pkg.sv
// Shared types and constants for the term-index sequencer.
// Optional early exit is enabled by defining TERM_SEQ_EARLY_EXIT_EN.
package term_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  function automatic int ch_w_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/term_idx_ctr.sv
// Loadable up/down term counter with terminal-index compare.
// Saturates at the terminal index so it can never wrap.
module term_idx_ctr
  import term_seq_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic [CNT_W-1:0] term_val_i,
  input  logic             dir_i,
  input  logic             step_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             hit_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] term_q, term_d;
  logic             dir_q, dir_d;

  assign hit_o = (cnt_q == term_q);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d  = cnt_q;
    term_d = term_q;
    dir_d  = dir_q;
    if (load_i) begin
      cnt_d  = load_val_i;
      term_d = term_val_i;
      dir_d  = dir_i;
    end else if (step_i && !hit_o) begin
      if (dir_q == MODE_DOWN)
        cnt_d = cnt_q - CNT_W'(1);
      else
        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      term_q <= '0;
      dir_q  <= MODE_UP;
    end else begin
      cnt_q  <= cnt_d;
      term_q <= term_d;
      dir_q  <= dir_d;
    end
  end

endmodule

// File: rtl/term_sequencer.sv
// Term/channel index sequencer feeding the coefficient ROM and MAC array.
// Define TERM_SEQ_EARLY_EXIT_EN to add the converged/early_exit ports.
module term_sequencer
  import term_seq_pkg::*;
#(
  parameter int CNT_W  = 5,
  parameter int NUM_CH = 4,
  parameter int CH_W   = ch_w_f(NUM_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_terms,
  input  logic             mode_down,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] term_cnt,
  output logic [CH_W-1:0]  ch_idx,
  output logic             last,
  output logic             coeff_rd_en,
  output logic             busy,
  output logic             done
`ifdef TERM_SEQ_EARLY_EXIT_EN
  ,
  input  logic             converged,
  output logic             early_exit
`endif
);

  localparam logic [CH_W-1:0] CH_MAX = CH_W'(NUM_CH - 1);

  state_e           state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             accept, ch_end, hit;
  logic             fin, conv;
  logic             load, step;
  logic [CNT_W-1:0] n_m1, ld_val, tv_val;

  assign n_m1   = num_terms - CNT_W'(1);
  assign ld_val = (mode_down == MODE_DOWN) ? n_m1 : '0;
  assign tv_val = (mode_down == MODE_DOWN) ? '0 : n_m1;

  // abort wins over a handshake in the same cycle
  assign out_valid   = (state_q == RUN);
  assign accept      = out_valid & out_ready & ~abort;
  assign ch_end      = (ch_q == CH_MAX);
  assign last        = out_valid & hit & ch_end;
  assign fin         = accept & ch_end & (hit | conv);
  assign coeff_rd_en = accept & (ch_q == '0);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE) & ~abort;
  assign ch_idx      = ch_q;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (num_terms != '0) begin
            state_d = RUN;
            load    = 1'b1;
            ch_d    = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept) begin
          if (fin) begin
            state_d = DONE;
          end else if (ch_end) begin
            ch_d = '0;
            step = 1'b1;
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  term_idx_ctr #(
    .CNT_W(CNT_W)
  ) u_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .load_val_i(ld_val),
    .term_val_i(tv_val),
    .dir_i     (mode_down),
    .step_i    (step),
    .cnt_o     (term_cnt),
    .hit_o     (hit)
  );

`ifdef TERM_SEQ_EARLY_EXIT_EN
  logic early_q;

  assign conv       = converged;
  assign early_exit = done & early_q;

  // set only on the cycle entering DONE through convergence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      early_q <= 1'b0;
    else
      early_q <= fin & ~hit;
  end
`else
  assign conv = 1'b0;
`endif

endmodule
